// File: rtl/motor_feedback_mc_if.sv
// motor_feedback_mc_if
//   Bundles the encoder pins, clear controls and position/period outputs of
//   motor_feedback_mc. clk and resetn stay plain ports on the module.
//   slave  : the tracker (consumes enc_*/clear_*, drives positions).
//   master : the register file / pin side.
//   Signals:
//     enc_a, enc_b [NUM_CH]      encoder inputs, asynchronous to clk
//     quad_mode                  0 = pulse counting, 1 = x4 quadrature
//     clear_abs [NUM_CH]         per-channel clear of abs_pos/period/err
//     clear_rel, clear_ts        clear all rel_pos / the timestamp
//     abs_pos, rel_pos, pos_diff, period [NUM_CH*CNT_W]
//     err [NUM_CH], count_clk [TS_W]
interface motor_feedback_mc_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
);
    logic [NUM_CH-1:0]       enc_a;
    logic [NUM_CH-1:0]       enc_b;
    logic                    quad_mode;
    logic [NUM_CH-1:0]       clear_abs;
    logic                    clear_rel;
    logic                    clear_ts;
    logic [NUM_CH*CNT_W-1:0] abs_pos;
    logic [NUM_CH*CNT_W-1:0] rel_pos;
    logic [NUM_CH*CNT_W-1:0] pos_diff;
    logic [NUM_CH*CNT_W-1:0] period;
    logic [NUM_CH-1:0]       err;
    logic [TS_W-1:0]         count_clk;

    modport slave (
        input  enc_a, enc_b, quad_mode, clear_abs, clear_rel, clear_ts,
        output abs_pos, rel_pos, pos_diff, period, err, count_clk
    );

    modport master (
        output enc_a, enc_b, quad_mode, clear_abs, clear_rel, clear_ts,
        input  abs_pos, rel_pos, pos_diff, period, err, count_clk
    );
endinterface

// File: rtl/motor_feedback_mc.sv
// motor_feedback_mc
//   Multi-channel encoder position tracker. Each A/B input is resynchronised
//   (SYNC_STAGES flops) and deglitched (FILT_LEN stable samples), then decoded
//   as rising edges of A (pulse mode) or x4 quadrature. Per channel it keeps a
//   wrapping signed abs_pos, a saturating normalised rel_pos, an edge-to-edge
//   period and a sticky illegal-transition flag. A shared timestamp runs freely.
//   Ports:
//     clk     single clock
//     resetn  asynchronous active-low reset
//     bus     motor_feedback_mc_if.slave (encoder pins, clears, outputs)
module motor_feedback_mc #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int TS_W        = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input logic                clk,
    input logic                resetn,
    motor_feedback_mc_if.slave bus
);
    // A inputs occupy [NUM_CH-1:0], B inputs [2*NUM_CH-1:NUM_CH]
    localparam int NSIG = 2 * NUM_CH;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q [NSIG];
    logic [NSIG-1:0]        raw, syn, flt, filt_q, filt_d;
    logic [3:0]             fcnt_q [NSIG];
    logic [3:0]             fcnt_d [NSIG];

    logic [1:0]        cur [NUM_CH];
    logic [1:0]        prev_q [NUM_CH];
    logic [1:0]        prev_d [NUM_CH];
    logic [NUM_CH-1:0] up_q, up_d, dn_q, dn_d, err_q, err_d, seen_q, seen_d;
    logic [CNT_W-1:0]  abs_q [NUM_CH];
    logic [CNT_W-1:0]  abs_d [NUM_CH];
    logic [CNT_W-1:0]  rel_q [NUM_CH];
    logic [CNT_W-1:0]  rel_d [NUM_CH];
    logic [CNT_W-1:0]  per_q [NUM_CH];
    logic [CNT_W-1:0]  per_d [NUM_CH];
    logic [CNT_W-1:0]  pcnt_q [NUM_CH];
    logic [CNT_W-1:0]  pcnt_d [NUM_CH];
    logic [CNT_W-1:0]  base [NUM_CH];
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              norm;
    logic [CNT_W-1:0]  mn;

    assign raw = {bus.enc_b, bus.enc_a};
    // With FILT_LEN = 0 the synchronised value feeds the decoder directly
    assign flt = (FILT_LEN == 0) ? syn : filt_q;

    always_comb begin
        syn    = '0;
        filt_d = filt_q;
        for (int unsigned k = 0; k < NSIG; k++) begin
            syn[k]    = sync_q[k][SYNC_STAGES-1];
            fcnt_d[k] = '0;
            if (syn[k] != filt_q[k]) begin
                if (fcnt_q[k] == 4'(FILT_LEN - 1)) filt_d[k] = syn[k];
                else                               fcnt_d[k] = fcnt_q[k] + 4'd1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) cur[i] = {flt[i], flt[NUM_CH+i]};
    end

    // Decode stage: registered into up_q/dn_q so the counters see it one cycle
    // later; err is taken at this stage and so flags one cycle ahead of abs_pos.
    always_comb begin
        up_d  = '0;
        dn_d  = '0;
        err_d = err_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            prev_d[i] = cur[i];
            if (bus.quad_mode) begin
                case ({prev_q[i], cur[i]})
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: up_d[i] = 1'b1;
                    4'b0100, 4'b1101, 4'b1011, 4'b0010: dn_d[i] = 1'b1;
                    4'b0011, 4'b1100, 4'b0110, 4'b1001: err_d[i] = 1'b1;
                    default: ;
                endcase
            end else begin
                up_d[i] = cur[i][1] & ~prev_q[i][1];
            end
            if (bus.clear_abs[i]) err_d[i] = 1'b0;
        end
    end

    // Normalisation works from registered rel_pos only
    always_comb begin
        norm = 1'b0;
        mn   = rel_q[0];
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            norm = norm | rel_q[i][CNT_W-1];
            if (rel_q[i] < mn) mn = rel_q[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) base[i] = norm ? (rel_q[i] - mn) : rel_q[i];
    end

    always_comb begin
        seen_d = seen_q;
        ts_d   = bus.clear_ts ? '0 : ts_q + TS_W'(1);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            abs_d[i]  = abs_q[i];
            per_d[i]  = per_q[i];
            pcnt_d[i] = (pcnt_q[i] == '1) ? pcnt_q[i] : pcnt_q[i] + ONE;
            rel_d[i]  = base[i];
            if (up_q[i]) begin
                abs_d[i] = abs_q[i] + ONE;
                if (base[i] != '1) rel_d[i] = base[i] + ONE;
            end
            if (dn_q[i]) begin
                abs_d[i] = abs_q[i] - ONE;
                if (base[i] != '0) rel_d[i] = base[i] - ONE;
            end
            if (up_q[i] | dn_q[i]) begin
                pcnt_d[i] = '0;
                seen_d[i] = 1'b1;
                if (seen_q[i]) per_d[i] = (pcnt_q[i] == '1) ? '1 : pcnt_q[i] + ONE;
            end
            if (bus.clear_abs[i]) begin
                abs_d[i]  = '0;
                per_d[i]  = '0;
                pcnt_d[i] = '0;
                seen_d[i] = 1'b0;
            end
            if (bus.clear_rel) rel_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned k = 0; k < NSIG; k++) begin
                sync_q[k] <= '0;
                fcnt_q[k] <= '0;
            end
            filt_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                prev_q[i] <= '0;
                abs_q[i]  <= '0;
                rel_q[i]  <= '0;
                per_q[i]  <= '0;
                pcnt_q[i] <= '0;
            end
            up_q   <= '0;
            dn_q   <= '0;
            err_q  <= '0;
            seen_q <= '0;
            ts_q   <= '0;
        end else begin
            for (int unsigned k = 0; k < NSIG; k++) begin
                sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], raw[k]};
                fcnt_q[k] <= fcnt_d[k];
            end
            filt_q <= filt_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                prev_q[i] <= prev_d[i];
                abs_q[i]  <= abs_d[i];
                rel_q[i]  <= rel_d[i];
                per_q[i]  <= per_d[i];
                pcnt_q[i] <= pcnt_d[i];
            end
            up_q   <= up_d;
            dn_q   <= dn_d;
            err_q  <= err_d;
            seen_q <= seen_d;
            ts_q   <= ts_d;
        end
    end

    always_comb begin
        bus.abs_pos  = '0;
        bus.rel_pos  = '0;
        bus.pos_diff = '0;
        bus.period   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bus.abs_pos[i*CNT_W +: CNT_W]  = abs_q[i];
            bus.rel_pos[i*CNT_W +: CNT_W]  = rel_q[i];
            bus.pos_diff[i*CNT_W +: CNT_W] = rel_q[i] - rel_q[0];
            bus.period[i*CNT_W +: CNT_W]   = per_q[i];
        end
        bus.err       = err_q;
        bus.count_clk = ts_q;
    end
endmodule
